fifo_vec_reader: RTL and testbench



---
 rtl/qr_pkg.sv | 20 ++
 rtl/fifo_vec_reader.sv | 133 +++++++++++++
 tb/tb_fifo_vec_reader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/qr_pkg.sv
// ============================================================================
// Module  : qr_pkg
// Brief   : Shared types and defaults for the FIFO vector reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package qr_pkg;

  localparam int unsigned c_DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_vec_reader.sv
// ============================================================================
// Module  : fifo_vec_reader
// Brief   : Drains num_vec vectors of VECTOR_LEN words from a FIFO controller
//           into a registered valid/ready stream with per-vector last marking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_vec_reader
  import qr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int unsigned VECTOR_LEN = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_vec,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned c_IDX_W = $clog2(VECTOR_LEN);
  localparam int unsigned c_POP_W = CNT_WIDTH + c_IDX_W;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(VECTOR_LEN - 1);

  rd_state_t             r_state;
  rd_state_t             w_state_next;
  logic [CNT_WIDTH-1:0]  r_vec_left;
  logic [c_IDX_W-1:0]    r_elem_idx;
  logic [c_POP_W-1:0]    r_popped;
  logic [c_POP_W-1:0]    r_total;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;

  logic                  w_accept;
  logic                  w_rd;
  logic                  w_out_last;
  logic [c_POP_W-1:0]    w_total;

  // Pop-side and accept-side are tracked separately: r_popped bounds rd,
  // r_elem_idx/r_vec_left follow the element sitting in the output register.
  assign w_total    = c_POP_W'(num_vec) * c_POP_W'(VECTOR_LEN);
  assign w_accept   = r_out_valid && out_ready;
  assign w_out_last = r_out_valid && (r_elem_idx == c_LAST_IDX);
  assign w_rd       = (r_state == RUN) && !empty && (!r_out_valid || out_ready)
                      && (r_popped < r_total);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (num_vec == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (w_accept && w_out_last && (r_vec_left == CNT_WIDTH'(1))) begin
          w_state_next = FINISH;
        end
      end
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_vec_left <= '0;
      r_elem_idx <= '0;
      r_popped   <= '0;
      r_total    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec_left <= num_vec;
            r_elem_idx <= '0;
            r_popped   <= '0;
            r_total    <= w_total;
          end
        end
        RUN: begin
          if (w_rd) begin
            r_popped <= r_popped + c_POP_W'(1);
          end
          if (w_accept) begin
            if (r_elem_idx == c_LAST_IDX) begin
              r_elem_idx <= '0;
              r_vec_left <= r_vec_left - CNT_WIDTH'(1);
            end else begin
              r_elem_idx <= r_elem_idx + c_IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A pop in the same cycle as acceptance refills the register, so no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_rd) begin
      r_out_data  <= r_data;
      r_out_valid <= 1'b1;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  assign rd        = w_rd;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = w_out_last;
  assign busy      = (r_state == RUN) || (r_state == FINISH);
  assign done      = (r_state == FINISH);

endmodule

`default_nettype wire

// File: tb/tb_fifo_vec_reader.sv
// ============================================================================
// Module  : tb_fifo_vec_reader
// Brief   : Directed self-checking bench for fifo_vec_reader with a queue
//           model of the FIFO controller and register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_vec_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned VL = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_vec;
  logic          empty;
  logic [DW-1:0] r_data;
  logic          rd;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  fifo_vec_reader #(.DATA_WIDTH(DW), .VECTOR_LEN(VL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
    .empty(empty), .r_data(r_data), .rd(rd), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] q[$];

  typedef struct {
    int num_vec;
    int preload;
    int late_cnt;
    int late_cyc;
    int stall_beat;
    int stall_len;
    int restart_cyc;
    int exp_beats;
    int exp_rd;
    int exp_stall;
    int exp_left;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_fifo();
    empty  = (q.size() == 0);
    r_data = empty ? '0 : q[0];
  endtask

  // Words are numbered 1..N per run; the reader must emit them in order.
  task automatic run_vec(input int id, input vec_t v);
    int beats, rds, stalls, done_cyc, first_b, last_b, nxt;
    logic rd_s;
    beats = 0; rds = 0; stalls = 0; done_cyc = -1; first_b = -1; last_b = -1;
    rd_s = 1'b0;
    q.delete();
    nxt = 1;
    for (int i = 0; i < v.preload; i++) begin q.push_back(DW'(nxt)); nxt++; end
    update_fifo();
    out_ready = 1'b1;
    num_vec   = CW'(v.num_vec);
    start     = 1'b1;
    for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rd_s && q.size() > 0) void'(q.pop_front());
      if (cyc == v.late_cyc) begin
        for (int i = 0; i < v.late_cnt; i++) begin q.push_back(DW'(nxt)); nxt++; end
      end
      if (cyc == v.restart_cyc) begin start = 1'b1; num_vec = CW'(5); end
      update_fifo();
      out_ready = !(beats == v.stall_beat && stalls < v.stall_len);
      @(negedge clk);
      rd_s = rd;
      if (out_valid) begin
        chk($sformatf("v%0d beat_data", id), 32'(out_data), 32'(beats + 1));
        chk($sformatf("v%0d beat_last", id), 32'(out_last), 32'((beats % VL) == VL - 1));
      end
      if (out_valid && !out_ready) begin
        stalls++;
        chk($sformatf("v%0d rd_in_stall", id), 32'(rd), 32'(0));
      end
      if (out_valid && out_ready) begin
        if (beats == 0) first_b = cyc;
        last_b = cyc;
        beats++;
      end
      if (rd) rds++;
      if (done) begin
        done_cyc = cyc;
        chk($sformatf("v%0d busy_at_done", id), 32'(busy), 32'(1));
      end
    end
    if (done_cyc < 0) chk($sformatf("v%0d timeout_no_done", id), 32'(0), 32'(1));
    chk($sformatf("v%0d beats", id), 32'(beats), 32'(v.exp_beats));
    chk($sformatf("v%0d rd_count", id), 32'(rds), 32'(v.exp_rd));
    chk($sformatf("v%0d stall_cycles", id), 32'(stalls), 32'(v.exp_stall));
    chk($sformatf("v%0d done_latency", id), 32'(done_cyc - last_b), 32'(1));
    if (rd_s && q.size() > 0) void'(q.pop_front());
    chk($sformatf("v%0d words_left", id), 32'(q.size()), 32'(v.exp_left));
    if (v.exp_stall == 0 && v.late_cnt == 0)
      chk($sformatf("v%0d sustained_rate", id), 32'(last_b - first_b), 32'(v.exp_beats - 1));
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_busy", id), 32'(busy), 32'(0));
    chk($sformatf("v%0d idle_done", id), 32'(done), 32'(0));
  endtask

  initial begin
    //        nv pre late lcyc sbeat slen rst beats rd stall left
    tbl[0] = '{2,  8,  0,  -1,  -1,  0,  -1,  8,  8,  0,  0};
    tbl[1] = '{2,  8,  0,  -1,   1,  3,  -1,  8,  8,  3,  0};
    tbl[2] = '{2,  2,  6,   5,  -1,  0,  -1,  8,  8,  0,  0};
    tbl[3] = '{2, 12,  0,  -1,  -1,  0,   2,  8,  8,  0,  4};
    tbl[4] = '{3, 12,  0,  -1,  -1,  0,  -1, 12, 12,  0,  0};
    tbl[5] = '{1,  6,  0,  -1,  -1,  0,  -1,  4,  4,  0,  2};

    reset = 1'b0; start = 1'b0; num_vec = '0; out_ready = 1'b0;
    q.delete();
    update_fifo();
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd", 32'(rd), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // Zero-length request: straight to FINISH, never pops.
    q.delete();
    for (int i = 1; i <= 4; i++) q.push_back(DW'(i));
    update_fifo();
    out_ready = 1'b1; num_vec = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_busy", 32'(busy), 32'(1));
    chk("zero_done", 32'(done), 32'(1));
    chk("zero_rd", 32'(rd), 32'(0));
    @(posedge clk); #1;
    chk("zero_busy_after", 32'(busy), 32'(0));
    chk("zero_done_after", 32'(done), 32'(0));
    chk("zero_rd_after", 32'(rd), 32'(0));
    chk("zero_words_left", 32'(q.size()), 32'(4));

    // Asynchronous reset after the third accepted beat.
    begin
      int beats;
      logic rd_s;
      beats = 0; rd_s = 1'b0;
      q.delete();
      for (int i = 1; i <= 8; i++) q.push_back(DW'(i));
      update_fifo();
      num_vec = CW'(2); start = 1'b1;
      for (int cyc = 0; cyc < 50 && beats < 3; cyc++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (rd_s && q.size() > 0) void'(q.pop_front());
        update_fifo();
        @(negedge clk);
        rd_s = rd;
        if (out_valid && out_ready) beats++;
      end
      chk("rstmid_reached_beat3", 32'(beats), 32'(3));
      #2;
      reset = 1'b0;
      #1;
      chk("rstmid_out_valid", 32'(out_valid), 32'(0));
      chk("rstmid_out_data", 32'(out_data), 32'(0));
      chk("rstmid_out_last", 32'(out_last), 32'(0));
      chk("rstmid_rd", 32'(rd), 32'(0));
      chk("rstmid_busy", 32'(busy), 32'(0));
      chk("rstmid_done", 32'(done), 32'(0));
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      chk("rstrel_rd", 32'(rd), 32'(0));
      @(posedge clk); #1;
      run_vec(6, '{1, 4, 0, -1, -1, 0, -1, 4, 4, 0, 0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
